// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's memory stage
// and the data memory responder.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder with
// programmable wait states and fault detection.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN =
    33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [32:0] off;
  logic        fault;
  logic        resp;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
  end

  // 33-bit offset: below-base wraps into bit 32,
  // so one compare covers both range limits
  assign off   = {1'b0, addr_q} - LO;
  assign fault = (addr_q[1:0] != 2'b00)
               || (off >= SPAN);
  assign idx   = off[AW+1:2];
  assign resp  = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (reset && resp && we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.ready = resp;
  assign bus.err   = resp && fault;
  assign bus.rdata = (resp && !we_q && !fault)
                   ? mem[idx] : '0;

endmodule
